// File: rtl/shift_register_rx.sv
// UART 8N1 receiver: 16x oversampled, midpoint sampling, pushes bytes to RX FIFO.
// Flags bad stop bits and FIFO overrun; dropped bytes leave din unchanged.
module shift_register_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  input  logic       fifo_full,
  output logic [7:0] din,
  output logic       write_enable,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       rx_busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("shift_register_rx: DIV must be >= 2");
  end

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic       s1_q, s2_q;
  logic       rx_s;
  logic [15:0] div_q, div_d;
  logic       os_tick;
  logic [2:0] state_q, state_d;
  logic [3:0] s_cnt_q, s_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] din_q, din_d;
  logic       we_q, we_d;
  logic       fe_q, fe_d;
  logic       oe_q, oe_d;

  assign rx_s    = s2_q;
  assign os_tick = (div_q == DIV_M1);

  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    din_d     = din_q;
    we_d      = 1'b0;
    fe_d      = 1'b0;
    oe_d      = 1'b0;
    div_d     = os_tick ? 16'd0 : div_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          // Align the tick phase to the start edge
          div_d   = 16'd0;
          s_cnt_d = 4'd0;
          state_d = START;
        end
      end
      START: begin
        if (os_tick) begin
          s_cnt_d = s_cnt_q + 4'd1;
          if (s_cnt_q == 4'd7) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              s_cnt_d   = 4'd0;
              bit_cnt_d = 3'd0;
              state_d   = DATA;
            end
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          s_cnt_d = s_cnt_q + 4'd1;
          if (s_cnt_q == 4'd15) begin
            sh_d      = {rx_s, sh_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (os_tick) begin
          s_cnt_d = s_cnt_q + 4'd1;
          if (s_cnt_q == 4'd15) begin
            if (!rx_s) begin
              fe_d    = 1'b1;
              state_d = WAIT_HIGH;
            end else if (fifo_full) begin
              oe_d    = 1'b1;
              state_d = IDLE;
            end else begin
              din_d   = sh_q;
              we_d    = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      div_q     <= '0;
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      fe_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      s1_q      <= rx_pin;
      s2_q      <= s1_q;
      div_q     <= div_d;
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      din_q     <= din_d;
      we_q      <= we_d;
      fe_q      <= fe_d;
      oe_q      <= oe_d;
    end
  end

  assign din           = din_q;
  assign write_enable  = we_q;
  assign framing_error = fe_q;
  assign overrun_error = oe_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shift_register_rx.sv
// Bench for shift_register_rx: serial line model feeding a scoreboard of
// expected {we,fe,oe,din} events checked whenever the DUT pulses an output.
module tb_shift_register_rx;

  localparam int BAUD = 19200;
  localparam int DIVT = 4;
  localparam int CLKF = BAUD * 16 * DIVT;
  localparam int BITC = 16 * DIVT;

  localparam logic [2:0] EV_WE = 3'b100;
  localparam logic [2:0] EV_FE = 3'b010;
  localparam logic [2:0] EV_OE = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic       fifo_full;
  logic [7:0] din;
  logic       write_enable;
  logic       framing_error;
  logic       overrun_error;
  logic       rx_busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  last;

  shift_register_rx #(
    .CLK_FREQ(CLKF),
    .BAUD_RATE(BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_pin(rx_pin),
    .fifo_full(fifo_full),
    .din(din),
    .write_enable(write_enable),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && (write_enable || framing_error || overrun_error)) begin
      logic [10:0] obs;
      obs = {write_enable, framing_error, overrun_error, din};
      if (exp_q.size() == 0) check("unexpected_pulse", 32'(obs), 32'h0);
      else check("event", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int bl);
    rx_pin = 1'b0;
    idle(bl);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      idle(bl);
    end
    rx_pin = stop;
    idle(bl);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back({EV_WE, b});
    last = b;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      idle(1);
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    rx_pin    = 1'b1;
    fifo_full = 1'b0;
    last      = 8'h00;
    idle(4);
    check("rst_din", 32'(din), 32'h00);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    check("rst_oe", 32'(overrun_error), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    idle(20);

    expect_byte(8'hA5);
    send(8'hA5, 1'b1, BITC);
    idle(10);
    drain("single");
    check("busy_after_a5", 32'(rx_busy), 32'd0);

    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'h3C);
    send(8'h00, 1'b1, BITC);
    send(8'hFF, 1'b1, BITC);
    send(8'h3C, 1'b1, BITC);
    idle(10);
    drain("back_to_back");

    expect_byte(8'hB5);
    send(8'hB5, 1'b1, BITC + 1);
    idle(10);
    drain("slow_baud");

    rx_pin = 1'b0;
    idle(5 * DIVT);
    rx_pin = 1'b1;
    idle(3 * BITC);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    expect_byte(8'h55);
    send(8'h55, 1'b1, BITC);
    idle(10);
    drain("after_glitch");

    exp_q.push_back({EV_FE, last});
    send(8'h81, 1'b0, BITC);
    idle(5 * BITC);
    check("wait_high_busy", 32'(rx_busy), 32'd1);
    drain("framing");
    rx_pin = 1'b1;
    idle(BITC);
    check("fe_recover_idle", 32'(rx_busy), 32'd0);
    expect_byte(8'h12);
    send(8'h12, 1'b1, BITC);
    idle(10);
    drain("after_framing");

    fifo_full = 1'b1;
    exp_q.push_back({EV_OE, last});
    send(8'h7E, 1'b1, BITC);
    idle(10);
    drain("overrun");
    check("overrun_din_hold", 32'(din), 32'h12);
    fifo_full = 1'b0;
    expect_byte(8'h34);
    send(8'h34, 1'b1, BITC);
    idle(10);
    drain("after_overrun");

    rx_pin = 1'b0;
    idle(BITC);
    for (int i = 0; i < 4; i++) begin
      rx_pin = (i < 2);
      idle(BITC);
    end
    rx_pin = 1'b0;
    idle(BITC / 2);
    rst = 1'b1;
    idle(2);
    check("mid_rst_din", 32'(din), 32'h00);
    check("mid_rst_we", 32'(write_enable), 32'd0);
    check("mid_rst_fe", 32'(framing_error), 32'd0);
    check("mid_rst_oe", 32'(overrun_error), 32'd0);
    check("mid_rst_busy", 32'(rx_busy), 32'd0);
    rx_pin = 1'b1;
    rst    = 1'b0;
    last   = 8'h00;
    idle(2 * BITC);
    expect_byte(8'h96);
    send(8'h96, 1'b1, BITC);
    idle(10);
    drain("after_reset");
    check("final_busy", 32'(rx_busy), 32'd0);

    idle(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_register_rx.md
# shift_register_rx

UART receive stage and the downstream partner of the transmit shift register: it consumes the serial line driven by `tx_pin` (remote or loopback) and pushes each received byte into the RX FIFO. The line is synchronised and oversampled 16× per bit. Each frame is 8N1 (start, 8 data LSB first, stop), and each bit is sampled once at its midpoint. Valid bytes are written with a one-cycle `write_enable` pulse. Bad stop bits and FIFO overflow are flagged, and the offending byte is dropped.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 19200: line rate in bits/s.
- `OVERSAMPLE`, 16: sample ticks per bit. Fixed at 16; other values are unsupported.
- Derived `DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE)`, integer-truncated. Default is 325, giving 5200 clk/bit. `DIV >= 2` is required (elaboration check).

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, synchronous and active-high.
- `rx_pin` in 1: asynchronous serial input. Idles high.
- `fifo_full` in 1: RX FIFO cannot accept a write.
- `din` out 8: received byte. Valid while `write_enable`=1 and held until the next byte is written.
- `write_enable` out 1: one-cycle FIFO write strobe.
- `framing_error` out 1: one-cycle pulse when the stop bit is sampled 0.
- `overrun_error` out 1: one-cycle pulse when a valid byte is dropped because `fifo_full`=1.
- `rx_busy` out 1: high in every state except IDLE.

## Operation
- **Input synchroniser:** `rx_pin` passes through a 2-flop synchroniser (both flops reset to 1) to form `rx_s`. All decisions use `rx_s`.
- **Tick generator:** a 16-bit divider counter produces `os_tick` when it equals DIV-1, then wraps to 0. The counter is forced to 0 on the cycle IDLE detects a start, so frame timing is aligned to the start edge.
- **Counters:** `s_cnt` (4 bits) counts `os_tick`s within a bit; `bit_cnt` (3 bits) counts data bits.
- **States:**
  - **IDLE:** when `rx_s`=0, clear `s_cnt` and go to START.
  - **START:** on each `os_tick`, increment `s_cnt`. At the 8th tick (`s_cnt`==7, mid start bit):
    - `rx_s`=1: false start; go to IDLE with no output.
    - `rx_s`=0: clear `s_cnt` and `bit_cnt`, go to DATA.
  - **DATA:** on each `os_tick`, increment `s_cnt`. When `s_cnt`==15:
    - Shift `rx_s` into the shift register MSB (right shift, so the LSB arrives first).
    - Increment `bit_cnt`.
    - After the 8th data bit, go to STOP.
  - **STOP:** when `s_cnt`==15 on an `os_tick` (mid stop bit):
    - `rx_s`=1 and `fifo_full`=0: load `din`, pulse `write_enable`, go to IDLE.
    - `rx_s`=1 and `fifo_full`=1: pulse `overrun_error`, leave `din` unchanged, go to IDLE.
    - `rx_s`=0: pulse `framing_error`, no write, go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. This prevents a break condition from retriggering as a start bit.
- Byte value 0x00 is received and written like any other byte; no data filtering is done.
- `fifo_full` is sampled only at the stop decision.

## Timing
- **Reset values:** `din`=0x00, `write_enable`=0, `framing_error`=0, `overrun_error`=0, `rx_busy`=0. State is IDLE, both synchroniser flops are 1, and all counters are 0.
- **Reset mid-frame:** returns everything to the reset values on the next edge. The partial byte is discarded.
- **Start detection:** 2 cycles of synchroniser latency from the `rx_pin` edge to `rx_s`, plus 1 cycle to enter START.
- **Start validation:** `rx_s` must be low at 8·DIV cycles after START entry (2600 clk at defaults). A low glitch shorter than about 8·DIV is rejected.
- **Bit sampling:** each data or stop bit is sampled 16·DIV cycles after the previous sample.
- **Outputs after the stop decision:** `write_enable`, `framing_error` and `overrun_error` are registered. Each is high for exactly one cycle, the cycle after the stop sample edge, and at most one of them fires per frame.
- **Back-to-back frames:** the block returns to IDLE at mid stop bit, so a start bit following the stop bit without idle gap is caught.
- **Baud tolerance:** ±2% combined baud mismatch between transmitter and receiver must still decode correctly. The default pairing with the 5208-clk/bit transmitter differs by 0.15%.

## Test plan
- **Loopback, single byte:** drive from the TX stage with 0xA5 → exactly one `write_enable` pulse with `din`=0xA5; `framing_error`=`overrun_error`=0; `rx_busy` back to 0.
- **Zero byte and back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap → three `write_enable` pulses in order with matching `din`.
- **Glitch rejection:** `rx_pin` low for 2000 clk, then high → no pulse on any output; state returns to IDLE; a following 0x55 is received correctly.
- **Framing error:** frame 0x81 with stop bit 0, line held low for 20000 clk, then high → one `framing_error` pulse and no `write_enable`; no new frame starts until the line goes high; the next 0x12 is received.
- **Overrun:** `fifo_full`=1 during frame 0x7E → one `overrun_error` pulse, no write, `din` holds its previous value. With `fifo_full`=0, the next byte is written.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xC3 → all outputs at reset values. Send a clean 0x96 after release → 0x96 received.
